ensm_sequencer: RTL and testbench

ENSM_SEQUENCER -- requirements
Module: ensm_sequencer

---
 rtl/ensm_sequencer.sv | 165 ++++++++++++++++
 tb/tb_ensm_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ensm_sequencer.sv
// Transceiver ENSM sequencer: steps enable/txnrx through guarded turn and settle phases before granting TX.
// Latency: grant at 1 + max(T,1) + max(S,1) cycles after tx_req is sampled in OFF/RX_ON; all outputs registered.
// Backpressure: tx_req is a level request; withdrawing it before grant aborts (counted), during TX ends TX.
module ensm_sequencer #(
  parameter int CNT_WIDTH = 16,
  parameter int OBS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 tx_req,
  input  logic                 tx_done,
  input  logic [CNT_WIDTH-1:0] turn_cycles,
  input  logic [CNT_WIDTH-1:0] settle_cycles,
  output logic                 tx_gnt,
  output logic                 enable,
  output logic                 txnrx,
  output logic [2:0]           state,
  output logic [OBS_WIDTH-1:0] abort_cnt
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RX_ON     = 3'd1,
    ST_TURN_TX   = 3'd2,
    ST_TX_SETTLE = 3'd3,
    ST_TX        = 3'd4,
    ST_TURN_RX   = 3'd5
  } state_t;

  localparam logic [OBS_WIDTH-1:0] ABORT_MAX = {OBS_WIDTH{1'b1}};

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [OBS_WIDTH-1:0]   abort_q, abort_d;
  logic                   enable_q, enable_d;
  logic                   txnrx_q, txnrx_d;
  logic                   gnt_q, gnt_d;

  // A requested dwell of zero is treated as one cycle; the counter holds cycles remaining after this one.
  function automatic logic [CNT_WIDTH-1:0] dwell_load(input logic [CNT_WIDTH-1:0] n);
    return (n == '0) ? '0 : n - CNT_WIDTH'(1);
  endfunction

  // Next-state, dwell counter and abort counter; tx_req withdrawal has priority over dwell expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    case (state_q)
      ST_OFF: begin
        if (tx_req) begin
          state_d = ST_TURN_TX;
          cnt_d   = dwell_load(turn_cycles);
        end else if (rx_en) begin
          state_d = ST_RX_ON;
        end
      end
      ST_RX_ON: begin
        if (tx_req) begin
          state_d = ST_TURN_TX;
          cnt_d   = dwell_load(turn_cycles);
        end else if (!rx_en) begin
          state_d = ST_OFF;
        end
      end
      ST_TURN_TX: begin
        if (!tx_req) begin
          state_d = ST_TURN_RX;
          cnt_d   = dwell_load(turn_cycles);
          if (abort_q != ABORT_MAX) abort_d = abort_q + OBS_WIDTH'(1);
        end else if (cnt_q == '0) begin
          state_d = ST_TX_SETTLE;
          cnt_d   = dwell_load(settle_cycles);
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_TX_SETTLE: begin
        if (!tx_req) begin
          state_d = ST_TURN_RX;
          cnt_d   = dwell_load(turn_cycles);
          if (abort_q != ABORT_MAX) abort_d = abort_q + OBS_WIDTH'(1);
        end else if (cnt_q == '0) begin
          state_d = ST_TX;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ST_TX: begin
        // tx_done is only honoured here; elsewhere it has no effect.
        if (tx_done || !tx_req) begin
          state_d = ST_TURN_RX;
          cnt_d   = dwell_load(turn_cycles);
        end
      end
      ST_TURN_RX: begin
        // A re-raised tx_req is only looked at on the exit cycle and skips RX_ON entirely.
        if (cnt_q == '0) begin
          if (tx_req) begin
            state_d = ST_TURN_TX;
            cnt_d   = dwell_load(turn_cycles);
          end else if (rx_en) begin
            state_d = ST_RX_ON;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode of the next state so the pins register alongside the state itself.
  always_comb begin
    enable_d = 1'b0;
    txnrx_d  = 1'b0;
    gnt_d    = 1'b0;
    case (state_d)
      ST_RX_ON:     enable_d = 1'b1;
      ST_TURN_TX:   txnrx_d  = 1'b1;
      ST_TX_SETTLE: begin
        enable_d = 1'b1;
        txnrx_d  = 1'b1;
      end
      ST_TX: begin
        enable_d = 1'b1;
        txnrx_d  = 1'b1;
        gnt_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters and output registers; reset overrides everything including an active TX.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      abort_q  <= '0;
      enable_q <= 1'b0;
      txnrx_q  <= 1'b0;
      gnt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      enable_q <= enable_d;
      txnrx_q  <= txnrx_d;
      gnt_q    <= gnt_d;
    end
  end

  assign state     = state_q;
  assign enable    = enable_q;
  assign txnrx     = txnrx_q;
  assign tx_gnt    = gnt_q;
  assign abort_cnt = abort_q;

endmodule

// File: tb/tb_ensm_sequencer.sv
// Bench for ensm_sequencer: directed latency/abort/reset scenarios followed by random traffic.
// Every cycle the DUT is compared against a time-stamped phase model; literal checks pin key latencies.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
module tb_ensm_sequencer;
  localparam int CW     = 8;
  localparam int OW     = 4;
  localparam int AB_MAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst, rx_en, tx_req, tx_done;
  logic [CW-1:0] turn_cycles, settle_cycles;
  logic          tx_gnt, enable, txnrx;
  logic [2:0]    state;
  logic [OW-1:0] abort_cnt;

  int checks = 0;
  int errors = 0;

  ensm_sequencer #(.CNT_WIDTH(CW), .OBS_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .tx_req(tx_req), .tx_done(tx_done),
    .turn_cycles(turn_cycles), .settle_cycles(settle_cycles),
    .tx_gnt(tx_gnt), .enable(enable), .txnrx(txnrx), .state(state), .abort_cnt(abort_cnt)
  );

  always #5 clk = ~clk;

  // Output table indexed by phase: OFF, RX_ON, TURN_TX, TX_SETTLE, TX, TURN_RX.
  bit en_tab  [6] = '{0, 1, 0, 1, 1, 0};
  bit txn_tab [6] = '{0, 0, 1, 1, 1, 0};
  bit gnt_tab [6] = '{0, 0, 0, 0, 1, 0};

  // Model: current phase, edge index at which it was entered, and how many cycles it must last.
  int m_st = 0, m_entry = 0, m_dwell = 0, m_ab = 0;
  int cyc = 0;
  bit have_prev = 0, prev_en = 0, prev_txn = 0, gnt_ever = 0;

  function automatic int at_least1(int n);
    return (n < 1) ? 1 : n;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic enter(int s);
    m_st    = s;
    m_entry = cyc + 1;
    if (s == 3)                m_dwell = at_least1(int'(settle_cycles));
    else if (s == 2 || s == 5) m_dwell = at_least1(int'(turn_cycles));
    else                       m_dwell = 0;
  endtask

  // Advance the model across edge number cyc using the inputs that edge will sample.
  task automatic model_edge();
    int spent;
    spent = cyc - m_entry + 1;
    if (rst) begin
      m_st = 0; m_ab = 0; m_entry = cyc + 1; m_dwell = 0;
    end else begin
      case (m_st)
        0: if (tx_req) enter(2); else if (rx_en) enter(1);
        1: if (tx_req) enter(2); else if (!rx_en) enter(0);
        2, 3: begin
          if (!tx_req) begin
            enter(5);
            if (m_ab < AB_MAX) m_ab++;
          end else if (spent >= m_dwell) begin
            enter(m_st == 2 ? 3 : 4);
          end
        end
        4: if (tx_done || !tx_req) enter(5);
        5: if (spent >= m_dwell) enter(tx_req ? 2 : (rx_en ? 1 : 0));
        default: ;
      endcase
    end
  endtask

  // One clock: model step, edge, then compare every output and the enable/txnrx ordering rule.
  task automatic cycle();
    logic [2:0]    es;
    logic [OW-1:0] ea;
    model_edge();
    @(posedge clk);
    #1;
    es = 3'(m_st);
    ea = OW'(m_ab);
    checks++;
    if (state !== es || enable !== en_tab[m_st] || txnrx !== txn_tab[m_st] ||
        tx_gnt !== gnt_tab[m_st] || abort_cnt !== ea) begin
      errors++;
      $display("FAIL model cycle %0d: got st=%0d en=%b txnrx=%b gnt=%b ab=%0d expected st=%0d en=%b txnrx=%b gnt=%b ab=%0d",
               cyc, state, enable, txnrx, tx_gnt, abort_cnt, es, en_tab[m_st], txn_tab[m_st], gnt_tab[m_st], ea);
    end
    if (have_prev && txnrx !== prev_txn) begin
      checks++;
      if (enable !== 1'b0) begin
        errors++;
        $display("FAIL txnrx_guard cycle %0d: txnrx changed with enable=%b, required enable=0", cyc, enable);
      end
    end
    if (have_prev && enable === 1'b1 && !prev_en) begin
      checks++;
      if (txnrx !== prev_txn) begin
        errors++;
        $display("FAIL enable_rise cycle %0d: txnrx=%b changed while enable rose, required %b", cyc, txnrx, prev_txn);
      end
    end
    have_prev = 1;
    prev_en   = (enable === 1'b1);
    prev_txn  = (txnrx === 1'b1);
    if (tx_gnt === 1'b1) gnt_ever = 1;
    cyc++;
  endtask

  task automatic wait_state(int s, int budget, string name);
    int n;
    n = 0;
    while (state !== 3'(s) && n < budget) begin
      cycle();
      n++;
    end
    check(name, int'(state), s);
  endtask

  initial begin
    int n, gnt_at, en_hi_at;
    bit en1, txn1;
    rst = 1; rx_en = 0; tx_req = 0; tx_done = 0;
    turn_cycles = 8'd4; settle_cycles = 8'd8;
    cycle(); cycle();
    check("reset_state", int'(state), 0);
    check("reset_outs", int'({enable, txnrx, tx_gnt}), 0);
    check("reset_abort", int'(abort_cnt), 0);

    // Receive enable straight out of reset.
    rst = 0; rx_en = 1;
    cycle();
    check("rx_state", int'(state), 1);
    check("rx_enable", int'(enable), 1);
    check("rx_txnrx", int'(txnrx), 0);

    // T=4, S=8 grant timing from RX_ON.
    tx_req = 1; gnt_at = 0; en_hi_at = 0; en1 = 1; txn1 = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (i == 1) begin en1 = enable; txn1 = txnrx; end
      if (gnt_at == 0 && tx_gnt === 1'b1) gnt_at = i;
      if (en_hi_at == 0 && i > 1 && enable === 1'b1) en_hi_at = i;
    end
    check("turn_enable_low", int'(en1), 0);
    check("turn_txnrx_high", int'(txn1), 1);
    check("settle_enable_at", en_hi_at, 5);
    check("grant_at", gnt_at, 13);

    // tx_done ends TX and returns to RX after the turn guard.
    tx_done = 1; tx_req = 0;
    cycle();
    tx_done = 0;
    check("done_outs_low", int'({enable, txnrx, tx_gnt}), 0);
    cycle(); cycle(); cycle();
    check("done_txnrx_idle", int'(txnrx), 0);
    cycle();
    check("done_enable_at5", int'(enable), 1);
    check("done_rx_state", int'(state), 1);

    // Repeated aborts during TX_SETTLE saturate the abort counter.
    turn_cycles = 8'd0; settle_cycles = 8'd3; gnt_ever = 0;
    for (int i = 0; i < AB_MAX + 3; i++) begin
      tx_req = 1;
      wait_state(3, 10, "abort_reach_settle");
      tx_req = 0;
      cycle();
      check("abort_to_turn_rx", int'(state), 5);
      if (i == 0) check("abort_first", int'(abort_cnt), 1);
      wait_state(1, 10, "abort_back_rx");
    end
    check("abort_saturated", int'(abort_cnt), AB_MAX);
    check("abort_no_grant", int'(gnt_ever), 0);

    // Zero turn/settle: one cycle each, then reset mid-TX.
    settle_cycles = 8'd0; tx_req = 1; n = 0;
    while (tx_gnt !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    check("zero_dwell_grant", n, 3);
    cycle();
    rst = 1; tx_req = 0;
    cycle();
    rst = 0;
    check("rst_tx_state", int'(state), 0);
    check("rst_tx_outs", int'({enable, txnrx, tx_gnt}), 0);
    check("rst_tx_abort", int'(abort_cnt), 0);
    wait_state(1, 5, "post_rst_rx");

    // tx_req re-raised inside TURN_RX goes straight back to TURN_TX.
    turn_cycles = 8'd3; settle_cycles = 8'd1; tx_req = 1;
    wait_state(4, 20, "rearm_reach_tx");
    tx_req = 0;
    cycle();
    check("rearm_turn_rx", int'(state), 5);
    tx_req = 1; n = 0;
    while (state === 3'd5 && n < 10) begin
      cycle();
      n++;
    end
    check("rearm_exit_turn_tx", int'(state), 2);
    tx_req = 0;
    wait_state(1, 30, "rearm_back_rx");

    // Full-scale turn value counts down without wrapping.
    turn_cycles = 8'd255; tx_req = 1;
    cycle();
    n = 1;
    while (state === 3'd2 && n < 400) begin
      cycle();
      n++;
    end
    check("long_turn_len", n - 1, 255);
    turn_cycles = 8'd2; tx_req = 0;
    wait_state(1, 300, "long_back_rx");

    // Random traffic, including mid-phase changes of the dwell inputs.
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) rx_en = ~rx_en;
      if ($urandom_range(0, 14) == 0) tx_req = ~tx_req;
      tx_done = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) turn_cycles   = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) settle_cycles = 8'($urandom_range(0, 6));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
